reg_writeback_ctrl: RTL and testbench

//  Write-side initiator for the 16x16 dual-write-port register file.
//  - Accepts writeback results from two pipeline producers (A = older, B = younger in program order).
//  - Queues them in program order.
//  - Drains up to two per cycle onto WriteReg1/2, WriteData1/2 and WriteEnable.
//  - Never presents two different data values for the same register in one cycle.
//  - Exports a pending-write scoreboard so the hazard unit stalls readers until the file is updated.

---
 rtl/reg_wb_pkg.sv | 26 ++
 rtl/reg_writeback_ctrl_fifo.sv | 72 +++++++
 rtl/reg_writeback_ctrl.sv | 159 +++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared widths, the queue entry type and small helpers for the
// register-file writeback controller.
package reg_wb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // How the two head entries are presented on the write ports this cycle.
    typedef enum logic [1:0] {
        DRAIN_NONE,
        DRAIN_ONE,
        DRAIN_PAIR,
        DRAIN_MERGE
    } drain_e;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
        return NREGS'(1) << r;
    endfunction

endpackage

// File: rtl/reg_writeback_ctrl_fifo.sv
// Circular writeback queue: ordered dual push, dual pop, peek of the two
// oldest entries and a per-slot valid vector for the pending scoreboard.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_push_n,
    input  wb_entry_t             i_wdata0,
    input  wb_entry_t             i_wdata1,
    input  logic [1:0]            i_pop_n,
    output wb_entry_t             o_h0,
    output wb_entry_t             o_h1,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [DEPTH-1:0]      o_valid,
    output wb_entry_t             o_entries [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr1;
    logic [PTR_W-1:0] w_rd_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

    // Storage write: first pushed entry lands at the tail, second right after it.
    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) begin
            r_mem[r_wr_ptr] <= i_wdata0;
        end
        if (i_push_n == 2'd2) begin
            r_mem[w_wr_ptr1] <= i_wdata1;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
            r_count  <= r_count + CNT_W'(i_push_n) - CNT_W'(i_pop_n);
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        o_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] w_off;
            w_off      = PTR_W'(i) - r_rd_ptr;
            o_valid[i] = CNT_W'(w_off) < r_count;
            o_entries[i] = r_mem[i];
        end
    end

    assign o_h0    = r_mem[r_rd_ptr];
    assign o_h1    = r_mem[w_rd_ptr1];
    assign o_count = r_count;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback initiator for the dual-write-port register file: accepts results
// from two producers in program order, drains up to two per cycle with
// same-register coalescing, and exports a pending-write scoreboard.
module reg_writeback_ctrl
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ADDR_W-1:0]      a_reg,
    input  logic [DATA_W-1:0]      a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [ADDR_W-1:0]      b_reg,
    input  logic [DATA_W-1:0]      b_data,
    output logic [ADDR_W-1:0]      WriteReg1,
    output logic [ADDR_W-1:0]      WriteReg2,
    output logic [DATA_W-1:0]      WriteData1,
    output logic [DATA_W-1:0]      WriteData2,
    output logic                   WriteEnable,
    output logic [NREGS-1:0]       pending,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        w_h0;
    wb_entry_t        w_h1;
    wb_entry_t        w_wdata0;
    wb_entry_t        w_wdata1;
    wb_entry_t        w_entries [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_free;
    logic             w_a_acc;
    logic             w_b_acc;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    drain_e           w_mode;

    logic [ADDR_W-1:0] r_reg1;
    logic [ADDR_W-1:0] r_reg2;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              r_we;
    logic [NREGS-1:0]  w_pending;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push_n  (w_push_n),
        .i_wdata0  (w_wdata0),
        .i_wdata1  (w_wdata1),
        .i_pop_n   (w_pop_n),
        .o_h0      (w_h0),
        .o_h1      (w_h1),
        .o_count   (w_count),
        .o_valid   (w_valid),
        .o_entries (w_entries)
    );

    // Ready depends only on registered occupancy; a same-cycle drain earns no credit.
    always_comb begin
        w_free  = CNT_W'(DEPTH) - w_count;
        a_ready = w_free >= CNT_W'(1);
        b_ready = a_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));
    end

    // Compact accepted results so the older one (A) always goes in first.
    always_comb begin
        w_a_acc  = a_valid && a_ready;
        w_b_acc  = b_valid && b_ready;
        w_push_n = {1'b0, w_a_acc} + {1'b0, w_b_acc};
        w_wdata0 = w_a_acc ? '{dest: a_reg, data: a_data} : '{dest: b_reg, data: b_data};
        w_wdata1 = '{dest: b_reg, data: b_data};
    end

    // Choose the drain shape from the start-of-cycle queue state.
    always_comb begin
        w_mode  = DRAIN_NONE;
        w_pop_n = 2'd0;
        if (w_count == CNT_W'(1)) begin
            w_mode  = DRAIN_ONE;
            w_pop_n = 2'd1;
        end else if (w_count >= CNT_W'(2)) begin
            w_mode  = (w_h0.dest == w_h1.dest) ? DRAIN_MERGE : DRAIN_PAIR;
            w_pop_n = 2'd2;
        end
    end

    // Registered write ports; a same-register pair carries the younger value on both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_reg1  <= '0;
            r_reg2  <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            unique case (w_mode)
                DRAIN_ONE: begin
                    r_we    <= 1'b1;
                    r_reg1  <= w_h0.dest;
                    r_reg2  <= w_h0.dest;
                    r_data1 <= w_h0.data;
                    r_data2 <= w_h0.data;
                end
                DRAIN_PAIR: begin
                    r_we    <= 1'b1;
                    r_reg1  <= w_h0.dest;
                    r_reg2  <= w_h1.dest;
                    r_data1 <= w_h0.data;
                    r_data2 <= w_h1.data;
                end
                DRAIN_MERGE: begin
                    r_we    <= 1'b1;
                    r_reg1  <= w_h1.dest;
                    r_reg2  <= w_h1.dest;
                    r_data1 <= w_h1.data;
                    r_data2 <= w_h1.data;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_reg1  <= '0;
                    r_reg2  <= '0;
                    r_data1 <= '0;
                    r_data2 <= '0;
                end
            endcase
        end
    end

    // Scoreboard: every queued destination plus whatever is on the ports this cycle.
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_pending = w_pending | reg_onehot(w_entries[i].dest);
            end
        end
        if (r_we) begin
            w_pending = w_pending | reg_onehot(r_reg1) | reg_onehot(r_reg2);
        end
    end

    assign WriteEnable = r_we;
    assign WriteReg1   = r_reg1;
    assign WriteReg2   = r_reg2;
    assign WriteData1  = r_data1;
    assign WriteData2  = r_data2;
    assign pending     = w_pending;
    assign count       = w_count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl against a queue-based reference model.
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic [3:0]  WriteReg1;
    logic [3:0]  WriteReg2;
    logic [15:0] WriteData1;
    logic [15:0] WriteData2;
    logic        WriteEnable;
    logic [15:0] pending;
    logic [2:0]  count;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [3:0]  m_r1;
    logic [3:0]  m_r2;
    logic [15:0] m_d1;
    logic [15:0] m_d2;

    int n_chk;
    int n_err;

    reg_writeback_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .WriteReg1   (WriteReg1),
        .WriteReg2   (WriteReg2),
        .WriteData1  (WriteData1),
        .WriteData2  (WriteData2),
        .WriteEnable (WriteEnable),
        .pending     (pending),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check all outputs.
    task automatic step(input logic rs,
                        input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic bv, input logic [3:0] br, input logic [15:0] bd);
        int          free;
        logic        ea;
        logic        eb;
        logic [15:0] ep;
        ent_t        e0;
        ent_t        e1;
        @(negedge clk);
        rst = rs; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #1;
        free = DEPTH - q.size();
        ea = (free >= 1);
        eb = av ? (free >= 2) : (free >= 1);
        check_val("a_ready", 32'(a_ready), 32'(ea));
        check_val("b_ready", 32'(b_ready), 32'(eb));
        if (rs) begin
            q.delete();
            m_we = 0; m_r1 = 0; m_r2 = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            if (q.size() == 0) begin
                m_we = 0; m_r1 = 0; m_r2 = 0; m_d1 = 0; m_d2 = 0;
            end else if (q.size() == 1) begin
                e0 = q.pop_front();
                m_we = 1; m_r1 = e0.dest; m_r2 = e0.dest; m_d1 = e0.data; m_d2 = e0.data;
            end else begin
                e0 = q.pop_front();
                e1 = q.pop_front();
                m_we = 1;
                if (e0.dest == e1.dest) begin
                    m_r1 = e1.dest; m_r2 = e1.dest; m_d1 = e1.data; m_d2 = e1.data;
                end else begin
                    m_r1 = e0.dest; m_r2 = e1.dest; m_d1 = e0.data; m_d2 = e1.data;
                end
            end
            if (av && ea) q.push_back('{dest: ar, data: ad});
            if (bv && eb) q.push_back('{dest: br, data: bd});
        end
        @(posedge clk);
        #1;
        ep = '0;
        foreach (q[i]) ep[q[i].dest] = 1'b1;
        if (m_we) begin
            ep[m_r1] = 1'b1;
            ep[m_r2] = 1'b1;
        end
        check_val("WriteEnable", 32'(WriteEnable), 32'(m_we));
        check_val("WriteReg1", 32'(WriteReg1), 32'(m_r1));
        check_val("WriteReg2", 32'(WriteReg2), 32'(m_r2));
        check_val("WriteData1", 32'(WriteData1), 32'(m_d1));
        check_val("WriteData2", 32'(WriteData2), 32'(m_d2));
        check_val("count", 32'(count), 32'(q.size()));
        check_val("pending", 32'(pending), 32'(ep));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1; a_valid = 0; a_reg = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_data = 0;
        m_we = 0; m_r1 = 0; m_r2 = 0; m_d1 = 0; m_d2 = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // single write, duplicated on both ports
        step(0, 1, 4'd3, 16'h1234, 0, 0, 0);
        idle(3);
        // dual write in one pulse
        step(0, 1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555);
        idle(3);
        // same-register pair coalesces to the younger value
        step(0, 1, 4'd7, 16'h1111, 1, 4'd7, 16'h2222);
        idle(3);
        // reset with writes queued and on the ports
        step(0, 1, 4'd5, 16'hBEEF, 1, 4'd6, 16'hCAFE);
        step(0, 1, 4'd5, 16'hF00D, 0, 0, 0);
        step(1, 1, 4'd8, 16'h0101, 1, 4'd9, 16'h0202);
        idle(2);

        // sustained dual traffic with distinct registers
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 4'((2 * i) % 16), 16'($urandom),
                    1, 4'((2 * i + 1) % 16), 16'($urandom));
        end
        idle(3);

        // random mix, small register range to provoke collisions
        for (int i = 0; i < 300; i++) begin
            logic        rs;
            logic        av;
            logic        bv;
            logic [3:0]  ar;
            logic [3:0]  br;
            logic [15:0] ad;
            logic [15:0] bd;
            rs = ($urandom_range(0, 49) == 0);
            av = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 3) != 0);
            ar = 4'($urandom_range(0, 5));
            br = 4'($urandom_range(0, 5));
            ad = 16'($urandom);
            bd = 16'($urandom);
            step(rs, av, ar, ad, bv, br, bd);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
